// File: rtl/image_read_pkg.sv
`default_nettype none
// ============================================================================
// Module   : image_read_pkg
// Purpose  : Config register map, FSM encoding and coordinate type for the
//            image read stream.
// Revision : 1.0 - initial release
// ============================================================================
package image_read_pkg;

  localparam int CFG_IR_IMG_W   = 1;
  localparam int CFG_IR_IMG_DH  = 2;
  localparam int CFG_IR_PAD     = 3;
  localparam int CFG_IR_CONV    = 4;
  localparam int CFG_IR_PAD_VAL = 5;
  localparam int CFG_IR_BASE    = 6;

  localparam int DH_D_LSB       = 16;
  localparam int PAD_L_LSB      = 24;
  localparam int PAD_R_LSB      = 16;
  localparam int PAD_T_LSB      = 8;
  localparam int PAD_B_LSB      = 0;
  localparam int CONV_SIDE_LSB  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ir_state_t;

  // Signed coordinate wide enough for negative padding plus a full step overshoot
  typedef logic signed [19:0] coord_t;

  function automatic coord_t to_coord(input logic [15:0] v);
    return $signed({4'b0000, v});
  endfunction

endpackage
`default_nettype wire

// File: rtl/image_read_fifo.sv
`default_nettype none
// ============================================================================
// Module   : image_read_fifo
// Purpose  : Synchronous FIFO with occupancy count; head word reads as zero
//            while empty.
// Revision : 1.0 - initial release
// ============================================================================
module image_read_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_wr_en;
  logic               w_rd_en;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign w_rd_en  = pop && (r_count != '0);
  assign w_wr_en  = push && ((r_count != c_cnt_w'(DEPTH)) || w_rd_en);
  assign count    = r_count;
  assign pop_data = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/image_read_stream.sv
`default_nettype none
// ============================================================================
// Module   : image_read_stream
// Purpose  : Walks a padded 3-D image one convolution window at a time and
//            streams the words through a latency-sized prefetch FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module image_read_stream
  import image_read_pkg::*;
#(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int RD_LATENCY = 3,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic                          next,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_val,
  output logic [MEM_AWIDTH-1:0]         rd_addr,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] rd_data,
  output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
  output logic                          image_last,
  output logic                          image_val,
  input  logic                          image_rdy
);

  localparam int c_data_w = GROUP_NB * IMG_WIDTH;
  localparam int c_cnt_w  = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam int c_fcnt_w = $clog2(FIFO_DEPTH + 1);
  localparam coord_t c_zero = '0;

  ir_state_t             r_state, w_state_nxt;
  logic [15:0]           r_img_w_m1, r_img_h_m1, r_img_d_m1, r_step;
  logic [7:0]            r_pad_l, r_pad_r, r_pad_t, r_pad_b, r_side;
  logic [IMG_WIDTH-1:0]  r_pad_val;
  logic [MEM_AWIDTH-1:0] r_base;
  coord_t                r_oy, r_ox;
  logic [15:0]           r_d;
  logic [7:0]            r_kr, r_kc;
  logic [RD_LATENCY-1:0] r_dl_val, r_dl_pad, r_dl_last;

  logic                  w_start, w_issue, w_room, w_inb;
  logic                  w_row_end, w_img_end, w_win_end, w_last_coord;
  coord_t                w_w, w_h, w_x, w_y, w_ox_nxt, w_oy_nxt;
  logic [7:0]            w_side_m1;
  logic [MEM_AWIDTH-1:0] w_lin;
  logic [c_cnt_w-1:0]    w_in_flight;
  logic [c_fcnt_w-1:0]   w_fifo_count;
  logic                  w_push, w_pop;
  logic [c_data_w:0]     w_push_data, w_head;

  assign w_start = (r_state == ST_IDLE) && next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_img_w_m1 <= '0;
      r_img_h_m1 <= '0;
      r_img_d_m1 <= '0;
      r_pad_l    <= '0;
      r_pad_r    <= '0;
      r_pad_t    <= '0;
      r_pad_b    <= '0;
      r_side     <= '0;
      r_step     <= '0;
      r_pad_val  <= '0;
      r_base     <= '0;
    end else if (cfg_valid && (r_state == ST_IDLE)) begin
      case (cfg_addr)
        CFG_AWIDTH'(CFG_IR_IMG_W): r_img_w_m1 <= cfg_data[15:0];
        CFG_AWIDTH'(CFG_IR_IMG_DH): begin
          r_img_d_m1 <= cfg_data[DH_D_LSB +: 16];
          r_img_h_m1 <= cfg_data[15:0];
        end
        CFG_AWIDTH'(CFG_IR_PAD): begin
          r_pad_l <= cfg_data[PAD_L_LSB +: 8];
          r_pad_r <= cfg_data[PAD_R_LSB +: 8];
          r_pad_t <= cfg_data[PAD_T_LSB +: 8];
          r_pad_b <= cfg_data[PAD_B_LSB +: 8];
        end
        CFG_AWIDTH'(CFG_IR_CONV): begin
          r_side <= cfg_data[CONV_SIDE_LSB +: 8];
          r_step <= cfg_data[15:0];
        end
        CFG_AWIDTH'(CFG_IR_PAD_VAL): r_pad_val <= cfg_data[IMG_WIDTH-1:0];
        CFG_AWIDTH'(CFG_IR_BASE):    r_base    <= cfg_data[MEM_AWIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign w_w       = to_coord(r_img_w_m1) + 20'sd1;
  assign w_h       = to_coord(r_img_h_m1) + 20'sd1;
  assign w_side_m1 = r_side - 8'd1;
  assign w_x       = r_ox + to_coord({8'd0, r_kc});
  assign w_y       = r_oy + to_coord({8'd0, r_kr});
  assign w_inb     = (w_x >= c_zero) && (w_x < w_w) && (w_y >= c_zero) && (w_y < w_h);
  assign w_ox_nxt  = r_ox + to_coord(r_step);
  assign w_oy_nxt  = r_oy + to_coord(r_step);
  // Next origin fits iff origin + side <= extent + trailing pad
  assign w_row_end = (w_ox_nxt + to_coord({8'd0, r_side})) > (w_w + to_coord({8'd0, r_pad_r}));
  assign w_img_end = (w_oy_nxt + to_coord({8'd0, r_side})) > (w_h + to_coord({8'd0, r_pad_b}));
  assign w_win_end = (r_kc == w_side_m1) && (r_kr == w_side_m1) && (r_d == r_img_d_m1);
  assign w_last_coord = w_win_end && w_row_end && w_img_end;

  // Modular arithmetic: truncating each operand to MEM_AWIDTH gives the same low bits
  assign w_lin = (MEM_AWIDTH'(r_d) * MEM_AWIDTH'(w_h) + MEM_AWIDTH'(w_y)) * MEM_AWIDTH'(w_w)
               + MEM_AWIDTH'(w_x);
  assign rd_val  = w_issue && w_inb;
  assign rd_addr = rd_val ? (r_base + w_lin) : '0;

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_in_flight = w_in_flight + c_cnt_w'(r_dl_val[i]);
    end
  end

  assign w_room = (c_cnt_w'(w_fifo_count) + w_in_flight) < c_cnt_w'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (next) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy    = 1'b1;
        w_issue = w_room;
        if (w_issue && w_last_coord) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if ((w_in_flight == '0) && (w_fifo_count == '0)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Loop nest: origin x (inner), origin y (outer); within a window d, kr, kc
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oy <= '0;
      r_ox <= '0;
      r_d  <= '0;
      r_kr <= '0;
      r_kc <= '0;
    end else if (w_start) begin
      r_oy <= -to_coord({8'd0, r_pad_t});
      r_ox <= -to_coord({8'd0, r_pad_l});
      r_d  <= '0;
      r_kr <= '0;
      r_kc <= '0;
    end else if (w_issue) begin
      if (r_kc != w_side_m1) begin
        r_kc <= r_kc + 8'd1;
      end else begin
        r_kc <= '0;
        if (r_kr != w_side_m1) begin
          r_kr <= r_kr + 8'd1;
        end else begin
          r_kr <= '0;
          if (r_d != r_img_d_m1) begin
            r_d <= r_d + 16'd1;
          end else begin
            r_d <= '0;
            if (!w_row_end) begin
              r_ox <= w_ox_nxt;
            end else begin
              r_ox <= -to_coord({8'd0, r_pad_l});
              r_oy <= w_oy_nxt;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dl_val  <= '0;
      r_dl_pad  <= '0;
      r_dl_last <= '0;
    end else begin
      r_dl_val[0]  <= w_issue;
      r_dl_pad[0]  <= !w_inb;
      r_dl_last[0] <= w_win_end;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_dl_val[i]  <= r_dl_val[i-1];
        r_dl_pad[i]  <= r_dl_pad[i-1];
        r_dl_last[i] <= r_dl_last[i-1];
      end
    end
  end

  assign w_push      = r_dl_val[RD_LATENCY-1];
  assign w_push_data = {r_dl_last[RD_LATENCY-1],
                        r_dl_pad[RD_LATENCY-1] ? {GROUP_NB{r_pad_val}} : rd_data};

  image_read_fifo #(
    .WIDTH (c_data_w + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (w_fifo_count)
  );

  assign image_val  = (w_fifo_count != '0);
  assign image_bus  = w_head[c_data_w-1:0];
  assign image_last = w_head[c_data_w];
  assign w_pop      = image_val && image_rdy;

endmodule
`default_nettype wire

// File: tb/tb_image_read_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_read_stream
// Purpose  : Scoreboard bench for image_read_stream with a latency-matched
//            memory model that returns address-derived words.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_image_read_stream;
  import image_read_pkg::*;

  localparam int L  = 3;
  localparam int FD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cfg_data = '0;
  logic [4:0]  cfg_addr = '0;
  logic        cfg_valid = 1'b0;
  logic        next = 1'b0;
  logic        busy, done, rd_val;
  logic [15:0] rd_addr;
  logic [63:0] rd_data;
  logic [63:0] image_bus;
  logic        image_last, image_val;
  logic        image_rdy = 1'b1;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  int          n_reads  = 0;
  int          n_done   = 0;
  int          exp_words, exp_reads;
  logic [15:0] mem_pipe [L];

  image_read_stream #(
    .CFG_DWIDTH(32), .CFG_AWIDTH(5), .RD_LATENCY(L), .GROUP_NB(4),
    .IMG_WIDTH(16), .MEM_AWIDTH(16), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr),
    .cfg_valid(cfg_valid), .next(next), .busy(busy), .done(done),
    .rd_val(rd_val), .rd_addr(rd_addr), .rd_data(rd_data),
    .image_bus(image_bus), .image_last(image_last), .image_val(image_val),
    .image_rdy(image_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    return {a + 16'h3000, a + 16'h2000, a + 16'h1000, a};
  endfunction

  always @(posedge clk) begin
    mem_pipe[0] <= rd_addr;
    for (int i = 1; i < L; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign rd_data = mem_word(mem_pipe[L-1]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (rd_val) n_reads++;
        if (done) begin
          n_done++;
          chk("done_after_last_word", 64'(sb_q.size()), 64'd0);
        end
        if (image_val && image_rdy) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h expected no word", image_bus);
          end else begin
            e = sb_q.pop_front();
            chk($sformatf("word%0d_data", n_acc), image_bus, e.data);
            chk($sformatf("word%0d_last", n_acc), 64'(image_last), 64'(e.last));
          end
          n_acc++;
        end
      end
    end
  endtask

  task automatic cfg_write(input int a, input logic [31:0] dat);
    @(posedge clk); #1;
    cfg_addr  = 5'(a);
    cfg_data  = dat;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic program_cfg(input int w, h, d, pl, pr, pt, pb, side, step, base,
                             input logic [15:0] pv);
    cfg_write(CFG_IR_IMG_W,   32'(w - 1));
    cfg_write(CFG_IR_IMG_DH,  {16'(d - 1), 16'(h - 1)});
    cfg_write(CFG_IR_PAD,     {8'(pl), 8'(pr), 8'(pt), 8'(pb)});
    cfg_write(CFG_IR_CONV,    {8'd0, 8'(side), 16'(step)});
    cfg_write(CFG_IR_PAD_VAL, {16'd0, pv});
    cfg_write(CFG_IR_BASE,    32'(base));
  endtask

  // Reference traversal: plain nested loops over origins and window elements
  task automatic gen_expected(input int w, h, d, pl, pr, pt, pb, side, step, base,
                              input logic [15:0] pv);
    exp_t e;
    int   x, y;
    exp_words = 0;
    exp_reads = 0;
    for (int oy = -pt; oy + side - 1 <= h - 1 + pb; oy += step)
      for (int ox = -pl; ox + side - 1 <= w - 1 + pr; ox += step)
        for (int dd = 0; dd < d; dd++)
          for (int kr = 0; kr < side; kr++)
            for (int kc = 0; kc < side; kc++) begin
              y = oy + kr;
              x = ox + kc;
              if (x >= 0 && x < w && y >= 0 && y < h) begin
                e.data = mem_word(16'(base + (dd * h + y) * w + x));
                exp_reads++;
              end else begin
                e.data = {4{pv}};
              end
              e.last = (dd == d - 1) && (kr == side - 1) && (kc == side - 1);
              sb_q.push_back(e);
              exp_words++;
            end
  endtask

  task automatic start_and_wait(input string tag, input int budget,
                                input bit stall_en, input bit perturb);
    bit stalled = 1'b0;
    int stall_cnt = 0;
    n_acc   = 0;
    n_reads = 0;
    n_done  = 0;
    @(posedge clk); #1;
    next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    for (int c = 0; c < budget && n_done == 0; c++) begin
      @(posedge clk); #1;
      if (perturb && c == 5) begin
        cfg_addr  = 5'(CFG_IR_BASE);
        cfg_data  = 32'h40;
        cfg_valid = 1'b1;
        next      = 1'b1;
      end else if (perturb && c == 6) begin
        cfg_valid = 1'b0;
        next      = 1'b0;
      end
      if (stall_en && !stalled && n_acc >= 2) begin
        image_rdy = 1'b0;
        stalled   = 1'b1;
      end else if (stalled && !image_rdy) begin
        stall_cnt++;
        if (stall_cnt == 20) begin
          chk({tag, "_reads_at_stall_end"}, 64'(n_reads), 64'(2 + FD));
          image_rdy = 1'b1;
        end
      end
    end
    chk({tag, "_done_within_budget"}, 64'(n_done > 0), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_done_pulses"}, 64'(n_done), 64'd1);
    chk({tag, "_words"},       64'(n_acc), 64'(exp_words));
    chk({tag, "_reads"},       64'(n_reads), 64'(exp_reads));
    chk({tag, "_leftover"},    64'(sb_q.size()), 64'd0);
    chk({tag, "_busy_low"},    64'(busy), 64'd0);
    sb_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},       64'(busy), 64'd0);
    chk({tag, "_done"},       64'(done), 64'd0);
    chk({tag, "_rd_val"},     64'(rd_val), 64'd0);
    chk({tag, "_rd_addr"},    64'(rd_addr), 64'd0);
    chk({tag, "_image_val"},  64'(image_val), 64'd0);
    chk({tag, "_image_last"}, 64'(image_last), 64'd0);
    chk({tag, "_image_bus"},  image_bus, 64'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("idle");

    // 1: 4x4, side 2, step 2, no padding
    program_cfg(4, 4, 1, 0, 0, 0, 0, 2, 2, 0, 16'h0000);
    gen_expected(4, 4, 1, 0, 0, 0, 0, 2, 2, 0, 16'h0000);
    start_and_wait("s1", 300, 1'b0, 1'b0);

    // 2: 4x4 padded by 1 on every side, side 3, step 1
    program_cfg(4, 4, 1, 1, 1, 1, 1, 3, 1, 0, 16'hABCD);
    gen_expected(4, 4, 1, 1, 1, 1, 1, 3, 1, 0, 16'hABCD);
    start_and_wait("s2", 2000, 1'b0, 1'b0);

    // 3: 10x5x8 padded by 1, side 2, step 1
    program_cfg(10, 5, 8, 1, 1, 1, 1, 2, 1, 0, 16'h5A5A);
    gen_expected(10, 5, 8, 1, 1, 1, 1, 2, 1, 0, 16'h5A5A);
    start_and_wait("s3", 6000, 1'b0, 1'b0);

    // 4: scenario 1 with a 20-cycle consumer stall before word 3
    program_cfg(4, 4, 1, 0, 0, 0, 0, 2, 2, 0, 16'h0000);
    gen_expected(4, 4, 1, 0, 0, 0, 0, 2, 2, 0, 16'h0000);
    start_and_wait("s4", 400, 1'b1, 1'b0);

    // 5: abort scenario 3 mid-run, then rerun it from scratch
    program_cfg(10, 5, 8, 1, 1, 1, 1, 2, 1, 0, 16'h5A5A);
    gen_expected(10, 5, 8, 1, 1, 1, 1, 2, 1, 0, 16'h5A5A);
    n_acc = 0;
    @(posedge clk); #1;
    next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    for (int c = 0; c < 2000 && n_acc < 300; c++) @(posedge clk);
    chk("s5_reached_mid_run", 64'(n_acc >= 300), 64'd1);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_outputs_zero("s5_abort");
    repeat (3) @(posedge clk);
    sb_q.delete();
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    program_cfg(10, 5, 8, 1, 1, 1, 1, 2, 1, 0, 16'h5A5A);
    gen_expected(10, 5, 8, 1, 1, 1, 1, 2, 1, 0, 16'h5A5A);
    start_and_wait("s5_rerun", 6000, 1'b0, 1'b0);

    // 6: cfg write and next pulse during RUN must both be ignored
    program_cfg(4, 4, 1, 0, 0, 0, 0, 2, 2, 0, 16'h0000);
    gen_expected(4, 4, 1, 0, 0, 0, 0, 2, 2, 0, 16'h0000);
    start_and_wait("s6", 300, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
